// File: rtl/sdram_init_monitor.sv
// SDRAM power-up sequence checker: PRECHARGE-all, two AUTO REFRESH, LOAD MODE, with tRP/tRC/tMRD gap checks.
// Define SDRAM_MON_EXTRA_REF_EN to accept additional AUTO REFRESH commands while waiting for LOAD MODE.
module sdram_init_monitor #(
  parameter int PWRUP_CYCLES = 10000,
  parameter int TRP_CYCLES   = 1,
  parameter int TRC_CYCLES   = 4,
  parameter int TMRD_CYCLES  = 2
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [3:0]  cmd,
  input  logic [11:0] sdram_addr,
  output logic        dev_ready,
  output logic        init_err,
  output logic [2:0]  err_code,
  output logic [11:0] mode_reg,
  output logic [3:0]  burst_len,
  output logic [1:0]  cas_lat,
  output logic [3:0]  ref_count
);

  localparam int PW = $clog2(PWRUP_CYCLES + 1);
  localparam logic [PW-1:0] PWR_MAX = PW'(PWRUP_CYCLES);
  localparam logic [3:0] TRP_G  = 4'(TRP_CYCLES);
  localparam logic [3:0] TRC_G  = 4'(TRC_CYCLES);
  localparam logic [3:0] TMRD_G = 4'(TMRD_CYCLES);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  typedef enum logic [2:0] {
    S_PWRUP, S_WAIT_PRE, S_WAIT_REF1, S_WAIT_REF2, S_WAIT_LMR, S_MRD, S_READY, S_ERROR
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pwr_cnt;
  logic [3:0]    gap_cnt;

  logic          is_nop, is_pre, is_ref, is_lmr, pwr_done;
  logic          err_set, accept, lmr_take, ref_take, ready_set;
  logic [2:0]    err_val;
  logic          mode_ok;
  logic [3:0]    burst_dec;
  logic [1:0]    cas_dec;

  assign is_nop   = cmd[3] | (cmd == CMD_NOP);
  assign is_pre   = (cmd == CMD_PRE);
  assign is_ref   = (cmd == CMD_REF);
  assign is_lmr   = (cmd == CMD_LMR);
  assign pwr_done = (pwr_cnt == PWR_MAX);

  // Mode register field decode; reserved encodings clear mode_ok
  always_comb begin
    mode_ok   = 1'b1;
    burst_dec = 4'd0;
    cas_dec   = 2'd0;
    case (sdram_addr[2:0])
      3'b000:  burst_dec = 4'd1;
      3'b001:  burst_dec = 4'd2;
      3'b010:  burst_dec = 4'd4;
      3'b011:  burst_dec = 4'd8;
      3'b111:  if (sdram_addr[3]) mode_ok = 1'b0;
      default: mode_ok = 1'b0;
    endcase
    case (sdram_addr[6:4])
      3'b010:  cas_dec = 2'd2;
      3'b011:  cas_dec = 2'd3;
      default: mode_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    err_val   = 3'd0;
    accept    = 1'b0;
    lmr_take  = 1'b0;
    ref_take  = 1'b0;
    ready_set = 1'b0;
    case (state)
      // The edge that first sees the full power-up count already evaluates PRECHARGE
      S_PWRUP, S_WAIT_PRE: begin
        if (state == S_PWRUP && !pwr_done) begin
          if (!is_nop) begin
            state_nxt = S_ERROR; err_set = 1'b1; err_val = 3'd1;
          end
        end else begin
          state_nxt = S_WAIT_PRE;
          if (!is_nop) begin
            if (is_pre && sdram_addr[10]) begin
              state_nxt = S_WAIT_REF1; accept = 1'b1;
            end else if (is_pre) begin
              state_nxt = S_ERROR; err_set = 1'b1; err_val = 3'd7;
            end else begin
              state_nxt = S_ERROR; err_set = 1'b1; err_val = 3'd2;
            end
          end
        end
      end
      S_WAIT_REF1: if (!is_nop) begin
        if (is_ref && gap_cnt >= TRP_G) begin
          state_nxt = S_WAIT_REF2; accept = 1'b1; ref_take = 1'b1;
        end else begin
          state_nxt = S_ERROR; err_set = 1'b1; err_val = is_ref ? 3'd3 : 3'd2;
        end
      end
      S_WAIT_REF2: if (!is_nop) begin
        if (is_ref && gap_cnt >= TRC_G) begin
          state_nxt = S_WAIT_LMR; accept = 1'b1; ref_take = 1'b1;
        end else begin
          state_nxt = S_ERROR; err_set = 1'b1; err_val = is_ref ? 3'd4 : 3'd2;
        end
      end
      S_WAIT_LMR: if (!is_nop) begin
        if (is_lmr) begin
          if (gap_cnt < TRC_G) begin
            state_nxt = S_ERROR; err_set = 1'b1; err_val = 3'd4;
          end else begin
            lmr_take = 1'b1;
            if (mode_ok) begin
              state_nxt = S_MRD; accept = 1'b1;
            end else begin
              state_nxt = S_ERROR; err_set = 1'b1; err_val = 3'd6;
            end
          end
        end
`ifdef SDRAM_MON_EXTRA_REF_EN
        else if (is_ref) begin
          if (gap_cnt >= TRC_G) begin
            accept = 1'b1; ref_take = 1'b1;
          end else begin
            state_nxt = S_ERROR; err_set = 1'b1; err_val = 3'd4;
          end
        end
`endif
        else begin
          state_nxt = S_ERROR; err_set = 1'b1; err_val = 3'd2;
        end
      end
      // gap_cnt restarted at LOAD MODE, so it doubles as the tMRD timer
      S_MRD: begin
        if (!is_nop) begin
          state_nxt = S_ERROR; err_set = 1'b1; err_val = 3'd5;
        end else if (gap_cnt >= TMRD_G) begin
          state_nxt = S_READY; ready_set = 1'b1;
        end
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= S_PWRUP;
      pwr_cnt   <= '0;
      gap_cnt   <= 4'd0;
      dev_ready <= 1'b0;
      init_err  <= 1'b0;
      err_code  <= 3'd0;
      mode_reg  <= 12'd0;
      burst_len <= 4'd0;
      cas_lat   <= 2'd0;
      ref_count <= 4'd0;
    end else begin
      state <= state_nxt;
      if (!pwr_done) pwr_cnt <= pwr_cnt + PW'(1);
      if (accept) gap_cnt <= 4'd1;
      else if (gap_cnt != 4'hF) gap_cnt <= gap_cnt + 4'd1;
      if (err_set) begin
        init_err <= 1'b1;
        err_code <= err_val;
      end
      if (lmr_take) mode_reg <= sdram_addr;
      if (lmr_take && mode_ok) begin
        burst_len <= burst_dec;
        cas_lat   <= cas_dec;
      end
      if (ref_take && ref_count != 4'hF) ref_count <= ref_count + 4'd1;
      if (ready_set) dev_ready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_init_monitor.sv
// Bench for sdram_init_monitor: LOAD MODE vector table, directed corner sequences, randomized episodes vs a reference model.
module tb_sdram_init_monitor;

  localparam int PWR  = 100;
  localparam int TRP  = 1;
  localparam int TRC  = 4;
  localparam int TMRD = 2;
`ifdef SDRAM_MON_EXTRA_REF_EN
  localparam bit EXTRA = 1'b1;
`else
  localparam bit EXTRA = 1'b0;
`endif

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;
  localparam logic [3:0] LMR = 4'b0000;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic [3:0]  cmd = NOP;
  logic [11:0] sdram_addr = 12'd0;
  logic        dev_ready, init_err;
  logic [2:0]  err_code;
  logic [11:0] mode_reg;
  logic [3:0]  burst_len;
  logic [1:0]  cas_lat;
  logic [3:0]  ref_count;

  sdram_init_monitor #(
    .PWRUP_CYCLES(PWR), .TRP_CYCLES(TRP), .TRC_CYCLES(TRC), .TMRD_CYCLES(TMRD)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .cmd(cmd), .sdram_addr(sdram_addr),
    .dev_ready(dev_ready), .init_err(init_err), .err_code(err_code),
    .mode_reg(mode_reg), .burst_len(burst_len), .cas_lat(cas_lat), .ref_count(ref_count)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: edge index since reset release, init step, timestamps of accepted commands
  int          m_k, m_step, m_last, m_lmr, m_code, m_bl, m_cl, m_refs;
  bit          m_err, m_ready;
  logic [11:0] m_mode;

  typedef struct {
    logic [11:0] addr;
    logic [2:0]  code;
    logic        ready;
    logic [11:0] mode;
    logic [3:0]  bl;
    logic [1:0]  cl;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_k = 0; m_step = 0; m_last = 0; m_lmr = 0; m_code = 0;
    m_bl = 0; m_cl = 0; m_refs = 0; m_err = 0; m_ready = 0; m_mode = 12'd0;
  endtask

  task automatic flag(input int code);
    m_err = 1; m_code = code;
  endtask

  task automatic model_step(input logic [3:0] c, input logic [11:0] a);
    int gap, b, cl, bl;
    bit nop, ok;
    m_k++;
    nop = c[3] || (c == NOP);
    gap = (m_k - m_last > 15) ? 15 : (m_k - m_last);
    if (m_err || m_ready) return;
    if (m_step == 4) begin
      if (!nop) flag(5);
      else if (m_k - m_lmr >= TMRD) m_ready = 1;
      return;
    end
    if (nop) return;
    if (m_k <= PWR) begin flag(1); return; end
    case (m_step)
      0: if (c == PRE) begin
           if (a[10]) begin m_step = 1; m_last = m_k; end else flag(7);
         end else flag(2);
      1: if (c == REF) begin
           if (gap >= TRP) begin m_step = 2; m_last = m_k; m_refs++; end else flag(3);
         end else flag(2);
      2: if (c == REF) begin
           if (gap >= TRC) begin m_step = 3; m_last = m_k; m_refs++; end else flag(4);
         end else flag(2);
      3: if (c == LMR) begin
           if (gap < TRC) flag(4);
           else begin
             m_mode = a;
             ok = 1; bl = 0;
             b = int'(a[2:0]);
             if (b < 4) bl = 1 << b;
             else if (b == 7 && !a[3]) bl = 0;
             else ok = 0;
             cl = int'(a[6:4]);
             if (cl != 2 && cl != 3) ok = 0;
             if (ok) begin
               m_bl = bl; m_cl = cl; m_step = 4; m_lmr = m_k; m_last = m_k;
             end else flag(6);
           end
         end else if (c == REF && EXTRA) begin
           if (gap >= TRC) begin m_last = m_k; if (m_refs < 15) m_refs++; end else flag(4);
         end else flag(2);
      default: ;
    endcase
  endtask

  function automatic logic [31:0] dut_vec();
    return {5'd0, dev_ready, init_err, err_code, mode_reg, burst_len, cas_lat, ref_count};
  endfunction

  function automatic logic [31:0] model_vec();
    return {5'd0, m_ready, m_err, 3'(m_code), m_mode, 4'(m_bl), 2'(m_cl), 4'(m_refs)};
  endfunction

  // One clock: drive, let the edge sample, then compare against the model
  task automatic tick(input logic [3:0] c, input logic [11:0] a);
    cmd = c; sdram_addr = a;
    @(posedge CLK);
    model_step(c, a);
    #1;
    chk("model", dut_vec(), model_vec());
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) tick(NOP, 12'd0);
  endtask

  task automatic gap_cmd(input logic [3:0] c, input logic [11:0] a, input int gap);
    nops(gap - 1);
    tick(c, a);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RSTn = 1'b0; cmd = NOP; sdram_addr = 12'd0;
    model_reset();
    #1;
    chk("reset_outputs", dut_vec(), 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;
  endtask

  task automatic valid_head();
    do_reset();
    nops(PWR);
    tick(PRE, 12'h400);
    gap_cmd(REF, 12'd0, 1);
    gap_cmd(REF, 12'd0, 4);
  endtask

  function automatic logic [3:0] rnd_expected();
    case (m_step)
      0: return PRE;
      1, 2: return REF;
      3: return ($urandom_range(0, 3) == 0) ? REF : LMR;
      default: return NOP;
    endcase
  endfunction

  initial begin
    vt[0] = '{12'h032, 3'd0, 1'b1, 12'h032, 4'd4, 2'd3};
    vt[1] = '{12'h012, 3'd6, 1'b0, 12'h012, 4'd0, 2'd0};
    vt[2] = '{12'h020, 3'd0, 1'b1, 12'h020, 4'd1, 2'd2};
    vt[3] = '{12'h021, 3'd0, 1'b1, 12'h021, 4'd2, 2'd2};
    vt[4] = '{12'h033, 3'd0, 1'b1, 12'h033, 4'd8, 2'd3};
    vt[5] = '{12'h027, 3'd0, 1'b1, 12'h027, 4'd0, 2'd2};
    vt[6] = '{12'h02F, 3'd6, 1'b0, 12'h02F, 4'd0, 2'd0};
    vt[7] = '{12'h024, 3'd6, 1'b0, 12'h024, 4'd0, 2'd0};
    vt[8] = '{12'h042, 3'd6, 1'b0, 12'h042, 4'd0, 2'd0};
    vt[9] = '{12'h232, 3'd0, 1'b1, 12'h232, 4'd4, 2'd3};
    model_reset();

    for (int v = 0; v < 10; v++) begin
      valid_head();
      gap_cmd(LMR, vt[v].addr, 4);
      tick(NOP, 12'd0);
      chk("tmrd_not_yet_ready", {31'd0, dev_ready}, 32'd0);
      tick(NOP, 12'd0);
      chk("tbl_ready",     {31'd0, dev_ready}, {31'd0, vt[v].ready});
      chk("tbl_err_code",  {29'd0, err_code},  {29'd0, vt[v].code});
      chk("tbl_init_err",  {31'd0, init_err},  {31'd0, (vt[v].code != 3'd0)});
      chk("tbl_mode_reg",  {20'd0, mode_reg},  {20'd0, vt[v].mode});
      chk("tbl_burst_len", {28'd0, burst_len}, {28'd0, vt[v].bl});
      chk("tbl_cas_lat",   {30'd0, cas_lat},   {30'd0, vt[v].cl});
      chk("tbl_ref_count", {28'd0, ref_count}, 32'd2);
    end

    // READY is terminal: later commands leave everything unchanged
    tick(PRE, 12'h400); tick(REF, 12'd0); nops(4); tick(LMR, 12'h020); nops(3);
    chk("ready_hold_mode", {20'd0, mode_reg}, 32'h232);
    chk("ready_hold_flags", {30'd0, dev_ready, init_err}, 32'd2);

    // Early PRECHARGE mid power-up; a deselected command beforehand is harmless
    do_reset();
    nops(9);
    tick(4'b1000, 12'd0);
    chk("deselect_is_nop", {31'd0, init_err}, 32'd0);
    nops(PWR / 2 - 11);
    tick(PRE, 12'h400);
    chk("early_err", {28'd0, init_err, err_code}, {28'd0, 1'b1, 3'd1});
    nops(PWR);
    tick(PRE, 12'h400);
    chk("early_sticky", {29'd0, err_code}, 32'd1);
    chk("early_not_ready", {31'd0, dev_ready}, 32'd0);

    // Boundary: last illegal edge of the power-up window
    do_reset();
    nops(PWR - 1);
    tick(PRE, 12'h400);
    chk("pwrup_boundary", {29'd0, err_code}, 32'd1);

    // PRECHARGE without A10, and wrong command first
    do_reset(); nops(PWR); tick(PRE, 12'h000);
    chk("pre_a10_low", {29'd0, err_code}, 32'd7);
    do_reset(); nops(PWR); tick(REF, 12'h000);
    chk("order_ref_first", {29'd0, err_code}, 32'd2);
    do_reset(); nops(PWR); tick(PRE, 12'h400); tick(4'b0011, 12'd0);
    chk("illegal_cmd", {29'd0, err_code}, 32'd2);

    // Second REFRESH too soon; later LOAD MODE is ignored
    do_reset(); nops(PWR); tick(PRE, 12'h400);
    gap_cmd(REF, 12'd0, 1); gap_cmd(REF, 12'd0, 2);
    chk("trc_violation", {29'd0, err_code}, 32'd4);
    gap_cmd(LMR, 12'h032, 4);
    chk("mode_frozen", {20'd0, mode_reg}, 32'd0);
    chk("ref_frozen", {28'd0, ref_count}, 32'd1);

    // Command inside tMRD
    valid_head(); gap_cmd(LMR, 12'h032, 4); tick(REF, 12'd0); nops(2);
    chk("tmrd_violation", {28'd0, dev_ready, err_code}, {28'd0, 1'b0, 3'd5});

    // Asynchronous reset mid-sequence, then a clean run
    valid_head();
    #2 RSTn = 1'b0;
    #1;
    chk("async_reset", dut_vec(), 32'd0);
    model_reset();
    @(negedge CLK); RSTn = 1'b1;
    nops(PWR); tick(PRE, 12'h400);
    gap_cmd(REF, 12'd0, 1); gap_cmd(REF, 12'd0, 4); gap_cmd(LMR, 12'h032, 4); nops(2);
    chk("after_reset_ready", {28'd0, dev_ready, err_code}, {28'd0, 1'b1, 3'd0});

    // Third REFRESH before LOAD MODE
    valid_head();
    gap_cmd(REF, 12'd0, 4);
    if (EXTRA) begin
      chk("extra_ref_count", {28'd0, ref_count}, 32'd3);
      gap_cmd(LMR, 12'h032, 4); nops(2);
      chk("extra_ready", {28'd0, dev_ready, err_code}, {28'd0, 1'b1, 3'd0});
    end else begin
      chk("extra_ref_err", {28'd0, init_err, err_code}, {28'd0, 1'b1, 3'd2});
      chk("extra_ref_count", {28'd0, ref_count}, 32'd2);
    end

    // Randomized episodes checked cycle by cycle against the model
    for (int e = 0; e < 25; e++) begin
      logic [3:0]  c;
      logic [11:0] a;
      do_reset();
      for (int i = 0; i < PWR; i++) begin
        if ($urandom_range(0, 299) == 0) tick(4'($urandom_range(0, 15)), 12'($urandom));
        else tick(NOP, 12'd0);
      end
      for (int i = 0; i < 80; i++) begin
        c = NOP;
        a = 12'($urandom);
        if ($urandom_range(0, 3) == 0) begin
          c = ($urandom_range(0, 9) < 7) ? rnd_expected() : 4'($urandom_range(0, 15));
          if (c == PRE) a[10] = ($urandom_range(0, 4) != 0);
          if (c == LMR && $urandom_range(0, 9) < 7) a = vt[$urandom_range(0, 9)].addr;
        end
        tick(c, a);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_init_monitor.md
Name: sdram_init_monitor

Overview:
- Responder-side checker for the SDRAM power-up sequence. Sits on the controller→SDRAM command/address bus, in parallel with the device or its model.
- Decodes {CS,RAS,CAS,WE} and address each clock and tracks the device's init state: power-up wait, PRECHARGE-all, two AUTO REFRESH, LOAD MODE REGISTER.
- Flags the first ordering or timing violation, latches the programmed mode register and asserts dev_ready once the device may accept traffic.

Parameters:
- PWRUP_CYCLES, 10000, clocks after reset release before any non-NOP command is legal (200 us at 50 MHz).
- TRP_CYCLES, 1, minimum clocks from PRECHARGE to the next command.
- TRC_CYCLES, 4, minimum clocks from AUTO REFRESH to the next command.
- TMRD_CYCLES, 2, clocks from LOAD MODE REGISTER to dev_ready.

Ports:
- CLK  in  1  system clock, rising edge.
- RSTn  in  1  asynchronous active-low reset.
- cmd  in  4  {CS,RAS,CAS,WE}. NOP=0111, PRECHARGE=0010, AUTO REFRESH=0001, LOAD MODE=0000.
- sdram_addr  in  12  SDRAM address bus (A11..A0).
- dev_ready  out  1  init complete, device usable.
- init_err  out  1  sticky violation flag.
- err_code  out  3  first violation code.
- mode_reg  out  12  address value captured at LOAD MODE.
- burst_len  out  4  decoded burst length (1/2/4/8; 0 = full page).
- cas_lat  out  2  decoded CAS latency (2 or 3).
- ref_count  out  4  AUTO REFRESH commands accepted during init.

Behaviour:
- Reset values: all outputs 0. State PWRUP, pwr_cnt=0, gap_cnt=0.
- Command decoding:
  - cmd[3]=1 (deselect) is treated as NOP.
  - Any cmd value other than the four listed is an order error.
- Power-up counter: pwr_cnt increments every clock after reset release and saturates at PWRUP_CYCLES.
- Gap counter: gap_cnt clears to 1 on the edge after any accepted non-NOP command, then increments and saturates at 15. The gap is checked when the next non-NOP command is sampled.
- States:
  - PWRUP: waiting for the power-up delay to expire.
  - WAIT_PRE: expects PRECHARGE.
  - WAIT_REF1: expects the first AUTO REFRESH.
  - WAIT_REF2: expects the second AUTO REFRESH.
  - WAIT_LMR: expects LOAD MODE.
  - MRD: LOAD MODE accepted, counting tMRD.
  - READY: init complete.
  - ERROR: violation detected.
- Transitions:
  - PWRUP: non-NOP sampled while pwr_cnt<PWRUP_CYCLES -> ERROR, code 1 (early). Otherwise pwr_cnt==PWRUP_CYCLES -> WAIT_PRE.
  - WAIT_PRE: PRECHARGE with A10=1 -> WAIT_REF1. PRECHARGE with A10=0 -> ERROR, code 7. Any other non-NOP -> ERROR, code 2 (order).
  - WAIT_REF1: REFRESH with gap>=TRP_CYCLES -> WAIT_REF2; smaller gap -> code 3. Other non-NOP -> code 2.
  - WAIT_REF2: REFRESH with gap>=TRC_CYCLES -> WAIT_LMR; smaller gap -> code 4. Other non-NOP -> code 2.
  - WAIT_LMR: LOAD MODE with gap>=TRC_CYCLES -> MRD. Smaller gap -> code 4. REFRESH -> see Optional Feature. Other non-NOP -> code 2.
  - LOAD MODE acceptance: on the same edge, latch mode_reg=sdram_addr and decode burst_len from A2:0 (000->1, 001->2, 010->4, 011->8, 111->0 if A3=0). A2:0 reserved, or A6:4 not 010/011 -> ERROR, code 6, mode_reg still latched.
  - MRD: any non-NOP -> ERROR, code 5. dev_ready rises on edge n+TMRD_CYCLES, where n is the LOAD MODE sample edge; state -> READY.
  - READY: terminal. Further commands are ignored and outputs hold.
  - ERROR: terminal until reset. init_err=1, err_code holds the first code, dev_ready=0, mode_reg/ref_count frozen.
- Outputs are registered and change on the edge that samples the triggering command.
- ref_count increments on each accepted REFRESH.
- Reset asserted mid-sequence returns all state and outputs to reset values asynchronously. The power-up wait restarts in full.

Optional Feature:
- Macro SDRAM_MON_EXTRA_REF_EN.
- Defined: in WAIT_LMR, REFRESH with gap>=TRC_CYCLES is accepted, stays in WAIT_LMR and increments ref_count (saturating at 15). A smaller gap -> code 4.
- Undefined: REFRESH in WAIT_LMR -> ERROR, code 2; ref_count never exceeds 2.

Test Plan:
- Reset release; NOPs for 10000 clocks; then PRE(A10=1), 1 NOP-free gap, REF at +1, REF at +5, LMR addr=0x032 at +9 -> dev_ready=1 at LMR+2, mode_reg=0x032, burst_len=4, cas_lat=3, ref_count=2, init_err=0.
- PRECHARGE at cycle 5000 -> init_err=1 next edge, err_code=1, dev_ready stays 0.
- Valid power-up; REF second issued 2 clocks after the first -> err_code=4; a later LMR does not change mode_reg (stays 0).
- Valid sequence; LMR addr=0x012 (CL=1) -> err_code=6, mode_reg=0x012, dev_ready=0.
- Valid LMR followed by REFRESH 1 clock later -> err_code=5, dev_ready=0. Reset pulse mid-sequence, then a full valid sequence -> dev_ready=1 and err_code=0.
- Three REFs 4 apart before LMR: with SDRAM_MON_EXTRA_REF_EN -> ref_count=3, dev_ready=1. Without it -> err_code=2 at the third REF.
